// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: counter instruction encodings, sequencer FSM states
// and the phase-detector flag encoder.
// Latency: n/a (types and a pure function only). Backpressure: n/a.
package adpll_pkg;

    // Instruction word driven to the phase-error up/down counter
    localparam logic [1:0] CNT_HOLD = 2'b00;
    localparam logic [1:0] CNT_UP   = 2'b01;
    localparam logic [1:0] CNT_DOWN = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ALIGN      = 2'd1,
        ST_ACCUMULATE = 2'd2,
        ST_DRAIN      = 2'd3
    } seq_state_t;

    // Both flags together mean the detector cannot decide; treat as no error
    function automatic logic [1:0] encode_instr(input logic up, input logic down);
        logic [1:0] instr;
        instr = CNT_HOLD;
        if (up && !down) begin
            instr = CNT_UP;
        end else if (down && !up) begin
            instr = CNT_DOWN;
        end
        return instr;
    endfunction

endpackage

// File: rtl/phase_count_sequencer_if.sv
// Sample bus from the phase-count sequencer to the loop filter.
// Latency: n/a (wires only). Backpressure: sample_ready_i from the loop filter.
// Ports: sample_o / sample_sat_o / sample_valid_o (sequencer -> filter),
//        sample_ready_i (filter -> sequencer).
interface phase_count_sequencer_if #(
    parameter int WIDTH = 20
);
    logic signed [WIDTH-1:0] sample_o;
    logic                    sample_valid_o;
    logic                    sample_sat_o;
    logic                    sample_ready_i;

    modport master (
        output sample_o,
        output sample_valid_o,
        output sample_sat_o,
        input  sample_ready_i
    );

    modport slave (
        input  sample_o,
        input  sample_valid_o,
        input  sample_sat_o,
        output sample_ready_i
    );
endinterface

// File: rtl/phase_count_sequencer_window.sv
// Reference-edge window counter: counts ref edges modulo PERIODS, flags the last edge.
// Latency: count updates on the edge after a control input; last_edge is combinational.
// Backpressure: none; clear beats load_one beats advance.
// Ports: fpga_clk_i, reset_i, clear, load_one, advance (inputs); last_edge (output).
module ref_window_counter #(
    parameter int PERIODS = 16
) (
    input  logic fpga_clk_i,
    input  logic reset_i,
    input  logic clear,
    input  logic load_one,
    input  logic advance,
    output logic last_edge
);
    // PERIODS must be at least 2, so the width is always at least one bit
    localparam int CW = $clog2(PERIODS);

    logic [CW-1:0] count_q;

    assign last_edge = (count_q == CW'(PERIODS - 1));

    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (load_one) begin
            // An edge landing in the drain cycle already belongs to the new window
            count_q <= CW'(1);
        end else if (advance) begin
            count_q <= last_edge ? '0 : count_q + CW'(1);
        end
    end

endmodule

// File: rtl/phase_count_sequencer.sv
// Phase-count sequencer: turns phase-detector flags into up/down counter instructions
//   over windows of PERIODS reference edges, then freezes, captures and clears the counter.
// Latency: flags -> count_instr_o one edge; window end -> sample_valid_o two edges after the last ref edge.
// Backpressure: sample held until sample_ready_i; a new capture overwrites it and sets sticky overrun_o.
// Ports: fpga_clk_i/reset_i; enable_i, ref_edge_i, pd_up_i, pd_down_i, counter_val_i in;
//   count_instr_o, counter_clear_o, overrun_o out; clear_overrun_i in; sample_bus (master) to loop filter.
module phase_count_sequencer
    import adpll_pkg::*;
#(
    parameter int WIDTH   = 20,
    parameter int PERIODS = 16
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    input  logic                    ref_edge_i,
    input  logic                    pd_up_i,
    input  logic                    pd_down_i,
    input  logic signed [WIDTH-1:0] counter_val_i,
    output logic [1:0]              count_instr_o,
    output logic                    counter_clear_o,
    output logic                    overrun_o,
    input  logic                    clear_overrun_i,
    phase_count_sequencer_if.master sample_bus
);

    // The counter saturates symmetrically, so both rails are +/-(2^(WIDTH-1)-1)
    localparam logic signed [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_NEG = -SAT_POS;

    seq_state_t state_q;
    seq_state_t state_d;

    logic                    win_clear;
    logic                    win_load_one;
    logic                    win_advance;
    logic                    win_last;
    logic                    capture;

    logic [1:0]              instr_q;
    logic signed [WIDTH-1:0] sample_q;
    logic                    sample_sat_q;
    logic                    sample_vld_q;
    logic                    overrun_q;

    ref_window_counter #(
        .PERIODS (PERIODS)
    ) u_window (
        .fpga_clk_i (fpga_clk_i),
        .reset_i    (reset_i),
        .clear      (win_clear),
        .load_one   (win_load_one),
        .advance    (win_advance),
        .last_edge  (win_last)
    );

    // ---------------------------------------------------------------- state register
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_ALIGN;
            end
            ST_ALIGN: begin
                if (ref_edge_i) state_d = ST_ACCUMULATE;
            end
            ST_ACCUMULATE: begin
                if (ref_edge_i && win_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_d = ST_ACCUMULATE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!enable_i) begin
            state_d = ST_IDLE;
        end
    end

    // ---------------------------------------------------------------- state outputs
    always_comb begin
        counter_clear_o = (state_q != ST_ACCUMULATE);
        // Holding the window at zero through IDLE and ALIGN makes the aligning edge start at count 0
        win_clear       = (state_q == ST_IDLE) || (state_q == ST_ALIGN);
        win_load_one    = (state_q == ST_DRAIN) && ref_edge_i;
        win_advance     = (state_q == ST_ACCUMULATE) && ref_edge_i;
        // The drain cycle always captures, even if enable_i falls during it
        capture         = (state_q == ST_DRAIN);
    end

    // ---------------------------------------------------------------- counter instruction
    // Only cycles that will be spent in ACCUMULATE may carry a count; the flag sampled on
    // the edge into DRAIN is dropped, leaving one blind cycle per window.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            instr_q <= CNT_HOLD;
        end else if (state_d == ST_ACCUMULATE) begin
            instr_q <= encode_instr(pd_up_i, pd_down_i);
        end else begin
            instr_q <= CNT_HOLD;
        end
    end

    // ---------------------------------------------------------------- sample capture and handshake
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            sample_q     <= '0;
            sample_sat_q <= 1'b0;
            sample_vld_q <= 1'b0;
        end else if (capture) begin
            // A capture coinciding with acceptance simply replaces the accepted sample
            sample_q     <= counter_val_i;
            sample_sat_q <= (counter_val_i == SAT_POS) || (counter_val_i == SAT_NEG);
            sample_vld_q <= 1'b1;
        end else if (sample_vld_q && sample_bus.sample_ready_i) begin
            sample_vld_q <= 1'b0;
        end
    end

    // Set has priority over clear so an overrun is never lost to a simultaneous clear
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            overrun_q <= 1'b0;
        end else if (capture && sample_vld_q && !sample_bus.sample_ready_i) begin
            overrun_q <= 1'b1;
        end else if (clear_overrun_i) begin
            overrun_q <= 1'b0;
        end
    end

    assign count_instr_o             = instr_q;
    assign overrun_o                 = overrun_q;
    assign sample_bus.sample_o       = sample_q;
    assign sample_bus.sample_sat_o   = sample_sat_q;
    assign sample_bus.sample_valid_o = sample_vld_q;

endmodule
